// File: rtl/pixel_flag_seq_pkg.sv
// Shared types and constants for the pixel flag sequencer: FSM states,
// register addresses and CTRL/STATUS bit positions.
package pixel_flag_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_GAP      = 2'd2,
    ST_HALT     = 2'd3
  } seq_state_t;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_SENT   = 2'd3;

  localparam int CTRL_ENABLE   = 0;
  localparam int CTRL_IRQ_EN   = 1;
  localparam int CTRL_CLR_TMO  = 2;
  localparam int CTRL_CLR_DONE = 3;
  localparam int CTRL_CLR_OVF  = 4;

  localparam int STAT_BUSY      = 0;
  localparam int STAT_EMPTY     = 1;
  localparam int STAT_FULL      = 2;
  localparam int STAT_TMO       = 3;
  localparam int STAT_OVF       = 4;
  localparam int STAT_DONE      = 5;
  localparam int STAT_LEVEL_LSB = 8;

endpackage

// File: rtl/pixel_flag_seq_fifo.sv
// Synchronous show-ahead FIFO holding queued pixel words. A push while full
// is accepted only if a pop frees a slot in the same cycle.
module pixel_flag_seq_fifo #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 24,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic             push_accepted,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop_ok;

  assign full          = (level == LW'(DEPTH));
  assign empty         = (level == '0);
  assign pop_ok        = pop & ~empty;
  assign push_accepted = push & (~full | pop_ok);
  assign head          = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_accepted) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_accepted) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)        rd_ptr <= rd_ptr + AW'(1);
      case ({push_accepted, pop_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/pixel_flag_sequencer.sv
// Avalon-MM fed pixel sequencer: queues RGB words and hands them to the display
// engine over a flag/ack handshake. Define PIXEL_FLAG_SEQ_TIMEOUT_EN for the ack timeout.
module pixel_flag_sequencer
  import pixel_flag_seq_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [23:0] pixel_data,
  output logic        pixel_flag,
  input  logic        pixel_ack,
  output logic        irq,
  output logic [1:0]  state_dbg
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  // Valid/ready: pixel_flag holds pixel_data stable until the cycle pixel_ack
  // is sampled high; that edge completes the transfer and drops the flag.
  seq_state_t  state, state_n;
  logic        wr, wr_data, wr_ctrl, wr_sent;
  logic        enable, irq_en, done, overflow, timeout_err;
  logic [15:0] sent_cnt;
  logic        clr_tmo, load_px, drop_flag, pop, tmo_expire;
  logic [23:0] fifo_head;
  logic        fifo_full, fifo_empty, push_accepted;
  logic [LW-1:0] fifo_level;
  logic [31:0] status_word;
  logic        unused_bits;

  assign wr      = chipselect & ~write_n;
  assign wr_data = wr & (address == ADDR_DATA);
  assign wr_ctrl = wr & (address == ADDR_CTRL);
  assign wr_sent = wr & (address == ADDR_SENT);
  assign clr_tmo = wr_ctrl & writedata[CTRL_CLR_TMO];
  assign unused_bits = ^writedata[31:24];

  pixel_flag_seq_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(24)) u_fifo (
    .clk           (clk),
    .reset         (reset),
    .push          (wr_data),
    .pop           (pop),
    .din           (writedata[23:0]),
    .head          (fifo_head),
    .full          (fifo_full),
    .empty         (fifo_empty),
    .push_accepted (push_accepted),
    .level         (fifo_level)
  );

`ifdef PIXEL_FLAG_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] tmo_cnt;

  assign tmo_expire = (state == ST_WAIT_ACK) && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == ST_WAIT_ACK && !pixel_ack && !tmo_expire) tmo_cnt <= tmo_cnt + TW'(1);
      else                                                   tmo_cnt <= '0;
      if (tmo_expire && !pixel_ack) timeout_err <= 1'b1;
      else if (clr_tmo)             timeout_err <= 1'b0;
    end
  end
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign tmo_expire  = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_n   = state;
    load_px   = 1'b0;
    drop_flag = 1'b0;
    pop       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable && !fifo_empty && !timeout_err) begin
          load_px = 1'b1;
          state_n = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (pixel_ack) begin
          drop_flag = 1'b1;
          pop       = 1'b1;
          state_n   = ST_GAP;
        end else if (tmo_expire) begin
          drop_flag = 1'b1;
          state_n   = ST_HALT;
        end
      end
      ST_GAP:  state_n = ST_IDLE;
      ST_HALT: if (clr_tmo) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      pixel_flag <= 1'b0;
      pixel_data <= '0;
      enable     <= 1'b0;
      irq_en     <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      sent_cnt   <= '0;
    end else begin
      state <= state_n;
      if (load_px) begin
        pixel_flag <= 1'b1;
        pixel_data <= fifo_head;
      end else if (drop_flag) begin
        pixel_flag <= 1'b0;
      end
      if (wr_ctrl) begin
        enable <= writedata[CTRL_ENABLE];
        irq_en <= writedata[CTRL_IRQ_EN];
      end
      // Done means the last queued pixel left; a same-cycle push keeps it clear.
      if (pop && fifo_level == LW'(1) && !push_accepted) done <= 1'b1;
      else if (wr_ctrl && writedata[CTRL_CLR_DONE])       done <= 1'b0;
      if (wr_data && !push_accepted)                     overflow <= 1'b1;
      else if (wr_ctrl && writedata[CTRL_CLR_OVF])       overflow <= 1'b0;
      if (wr_sent)  sent_cnt <= '0;
      else if (pop) sent_cnt <= sent_cnt + 16'd1;
    end
  end

  always_comb begin
    status_word                 = '0;
    status_word[STAT_BUSY]      = (state != ST_IDLE);
    status_word[STAT_EMPTY]     = fifo_empty;
    status_word[STAT_FULL]      = fifo_full;
    status_word[STAT_TMO]       = timeout_err;
    status_word[STAT_OVF]       = overflow;
    status_word[STAT_DONE]      = done;
    status_word[STAT_LEVEL_LSB +: 8] = 8'(fifo_level);
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CTRL:   readdata = {30'd0, irq_en, enable};
      ADDR_STATUS: readdata = status_word;
      ADDR_SENT:   readdata = {16'd0, sent_cnt};
      default:     readdata = '0;
    endcase
  end

  assign irq       = irq_en & (timeout_err | done | overflow);
  assign state_dbg = state;

endmodule

// File: tb/tb_pixel_flag_sequencer.sv
// Self-checking bench for pixel_flag_sequencer: queue-based reference model of the
// register file and pixel stream, randomized words and ack delays.
module tb_pixel_flag_sequencer;

  localparam int DEPTH = 8;
  localparam int TMO   = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [23:0] pixel_data;
  logic        pixel_flag;
  logic        pixel_ack = 1'b0;
  logic        irq;
  logic [1:0]  state_dbg;

  int tests_run = 0;
  int tests_failed = 0;

  // reference model
  logic [23:0] exp_q[$];
  int          m_sent = 0;
  bit          m_done = 0;
  bit          m_ovf = 0;

  pixel_flag_sequencer #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .pixel_data (pixel_data),
    .pixel_flag (pixel_flag),
    .pixel_ack  (pixel_ack),
    .irq        (irq),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic void m_push(input logic [23:0] w);
    if (exp_q.size() < DEPTH) exp_q.push_back(w);
    else m_ovf = 1;
  endfunction

  function automatic logic [31:0] exp_status(input bit busy, input bit tmo);
    logic [31:0] s;
    s = '0;
    s[0] = busy;
    s[1] = (exp_q.size() == 0);
    s[2] = (exp_q.size() == DEPTH);
    s[3] = tmo;
    s[4] = m_ovf;
    s[5] = m_done;
    s[15:8] = 8'(exp_q.size());
    return s;
  endfunction

  // All driver tasks start and end just after a falling edge.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1 d = readdata;
  endtask

  task automatic push_word(input logic [23:0] w);
    bus_write(2'd0, {8'hA5, w});
    m_push(w);
  endtask

  task automatic wait_flag(output bit seen);
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      if (pixel_flag === 1'b1) begin seen = 1; break; end
      @(negedge clk);
    end
  endtask

  task automatic do_pixel(input int delay, output logic [23:0] d, output bit seen, output bit stable);
    stable = 1; d = '0;
    wait_flag(seen);
    if (!seen) return;
    d = pixel_data;
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      if (pixel_flag !== 1'b1 || pixel_data !== d) stable = 0;
    end
    pixel_ack = 1'b1;
    @(negedge clk);
    pixel_ack = 1'b0;
    if (pixel_flag !== 1'b0) stable = 0;
  endtask

  task automatic drain_check(input int dmin, input int dmax);
    logic [23:0] d, e;
    bit seen, stable;
    while (exp_q.size() > 0) begin
      do_pixel($urandom_range(dmax, dmin), d, seen, stable);
      tests_run++;
      if (!seen) begin
        tests_failed++;
        $display("FAIL drain_flag: got no pixel_flag within budget, required flag for %h", exp_q[0]);
        exp_q.delete();
        break;
      end
      e = exp_q.pop_front();
      m_sent = (m_sent + 1) & 16'hFFFF;
      if (exp_q.size() == 0) m_done = 1;
      if (d !== e || !stable) begin
        tests_failed++;
        $display("FAIL drain_data: got %h (stable=%0d) required %h (stable=1)", d, stable, e);
      end
      @(negedge clk);
      tests_run++;
      if (pixel_flag !== 1'b0) begin
        tests_failed++;
        $display("FAIL gap_cycle: got flag %b required 0", pixel_flag);
      end
    end
  endtask

  task automatic cleanup();
    bus_write(2'd1, 32'h1C);
    bus_write(2'd3, 32'h0);
    m_done = 0; m_ovf = 0; m_sent = 0;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    bus_read(2'd2, r);
    tests_run++;
    if (r !== 32'h2 || pixel_flag !== 1'b0 || pixel_data !== 24'h0 || irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: got status %h flag %b data %h irq %b required 2/0/0/0", r, pixel_flag, pixel_data, irq);
    end
    bus_read(2'd1, r);
    tests_run++;
    if (r !== 32'h0) begin tests_failed++; $display("FAIL reset_ctrl: got %h required 0", r); end
    bus_read(2'd3, r);
    tests_run++;
    if (r !== 32'h0) begin tests_failed++; $display("FAIL reset_sent: got %h required 0", r); end
  endtask

  task automatic test_two_pixels();
    logic [31:0] r;
    push_word(24'h123456);
    push_word(24'hABCDEF);
    bus_write(2'd1, 32'h3);
    tests_run++;
    if (pixel_flag !== 1'b0) begin tests_failed++; $display("FAIL flag_latency_early: got %b required 0", pixel_flag); end
    @(negedge clk);
    tests_run++;
    if (pixel_flag !== 1'b1) begin tests_failed++; $display("FAIL flag_latency: got %b required 1", pixel_flag); end
    drain_check(2, 2);
    bus_read(2'd3, r);
    tests_run++;
    if (r !== 32'(m_sent) || m_sent != 2) begin tests_failed++; $display("FAIL two_sent: got %h required 2", r); end
    bus_read(2'd2, r);
    tests_run++;
    if (r !== exp_status(0, 0) || r !== 32'h22) begin tests_failed++; $display("FAIL two_status: got %h required 22", r); end
    tests_run++;
    if (irq !== 1'b1) begin tests_failed++; $display("FAIL two_irq: got %b required 1", irq); end
    cleanup();
  endtask

  task automatic test_overflow();
    logic [31:0] r;
    for (int i = 0; i < 9; i++) push_word(24'($urandom));
    bus_read(2'd2, r);
    tests_run++;
    if (r !== exp_status(0, 0) || r[15:0] !== 16'h0814) begin
      tests_failed++; $display("FAIL overflow_status: got %h required %h", r, exp_status(0, 0));
    end
    tests_run++;
    if (irq !== 1'b0) begin tests_failed++; $display("FAIL overflow_irq_masked: got %b required 0", irq); end
    bus_write(2'd1, 32'h1);
    drain_check(0, 3);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (pixel_flag !== 1'b0) break;
    end
    tests_run++;
    if (pixel_flag !== 1'b0) begin tests_failed++; $display("FAIL ninth_word: got flag %b required 0", pixel_flag); end
    bus_read(2'd2, r);
    tests_run++;
    if (r !== exp_status(0, 0)) begin tests_failed++; $display("FAIL overflow_drained: got %h required %h", r, exp_status(0, 0)); end
    cleanup();
  endtask

  task automatic test_full_push_pop();
    logic [31:0] r;
    logic [23:0] w, e;
    bit seen;
    for (int i = 0; i < DEPTH; i++) push_word(24'($urandom));
    bus_write(2'd1, 32'h1);
    wait_flag(seen);
    w = 24'($urandom);
    e = exp_q.pop_front();
    m_sent++;
    m_push(w);
    tests_run++;
    if (!seen || pixel_data !== e) begin tests_failed++; $display("FAIL full_pp_data: got %h required %h", pixel_data, e); end
    pixel_ack = 1'b1; address = 2'd0; writedata = {8'h0, w}; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    pixel_ack = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    bus_read(2'd2, r);
    tests_run++;
    if (r !== exp_status(1, 0) || r[15:0] !== 16'h0805) begin
      tests_failed++; $display("FAIL full_push_pop: got %h required %h", r, exp_status(1, 0));
    end
    @(negedge clk);
    drain_check(0, 2);
    bus_read(2'd3, r);
    tests_run++;
    if (r !== 32'(m_sent)) begin tests_failed++; $display("FAIL full_pp_sent: got %h required %h", r, m_sent); end
    cleanup();
  endtask

  task automatic test_enable_clear();
    logic [31:0] r;
    logic [23:0] e;
    bit seen;
    for (int i = 0; i < 3; i++) push_word(24'($urandom));
    bus_write(2'd1, 32'h1);
    wait_flag(seen);
    e = exp_q.pop_front();
    m_sent++;
    bus_write(2'd1, 32'h0);
    tests_run++;
    if (!seen || pixel_flag !== 1'b1 || pixel_data !== e) begin
      tests_failed++; $display("FAIL en_clear_hold: got flag %b data %h required 1 %h", pixel_flag, pixel_data, e);
    end
    pixel_ack = 1'b1;
    @(negedge clk);
    pixel_ack = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (pixel_flag !== 1'b0) break;
    end
    tests_run++;
    if (pixel_flag !== 1'b0) begin tests_failed++; $display("FAIL en_clear_stop: got flag %b required 0", pixel_flag); end
    bus_read(2'd3, r);
    tests_run++;
    if (r !== 32'(m_sent)) begin tests_failed++; $display("FAIL en_clear_sent: got %h required %h", r, m_sent); end
    bus_read(2'd2, r);
    tests_run++;
    if (r !== exp_status(0, 0)) begin tests_failed++; $display("FAIL en_clear_status: got %h required %h", r, exp_status(0, 0)); end
    bus_write(2'd1, 32'h1);
    drain_check(0, 3);
    cleanup();
  endtask

  task automatic test_random();
    logic [31:0] r;
    int n;
    bit ie;
    for (int round = 0; round < 4; round++) begin
      n = $urandom_range(10, 1);
      for (int i = 0; i < n; i++) push_word(24'($urandom));
      bus_read(2'd2, r);
      tests_run++;
      if (r !== exp_status(0, 0)) begin tests_failed++; $display("FAIL rand_fill_status: got %h required %h", r, exp_status(0, 0)); end
      ie = 1'($urandom_range(1, 0));
      bus_write(2'd1, {30'd0, ie, 1'b1});
      drain_check(0, 4);
      bus_read(2'd3, r);
      tests_run++;
      if (r !== 32'(m_sent)) begin tests_failed++; $display("FAIL rand_sent: got %h required %h", r, m_sent); end
      bus_read(2'd2, r);
      tests_run++;
      if (r !== exp_status(0, 0)) begin tests_failed++; $display("FAIL rand_status: got %h required %h", r, exp_status(0, 0)); end
      tests_run++;
      if (irq !== (ie & (m_done | m_ovf))) begin tests_failed++; $display("FAIL rand_irq: got %b required %b", irq, ie & (m_done | m_ovf)); end
      bus_write(2'd1, 32'h18);
      m_done = 0; m_ovf = 0;
    end
    cleanup();
  endtask

  task automatic test_timeout();
    logic [31:0] r;
    logic [23:0] w;
    bit seen;
    int highs;
    w = 24'($urandom);
    push_word(w);
    bus_write(2'd1, 32'h3);
    wait_flag(seen);
    highs = 0;
`ifdef PIXEL_FLAG_SEQ_TIMEOUT_EN
    while (pixel_flag === 1'b1 && highs < 40) begin highs++; @(negedge clk); end
    tests_run++;
    if (highs != TMO) begin tests_failed++; $display("FAIL timeout_len: got %0d cycles required %0d", highs, TMO); end
    bus_read(2'd2, r);
    tests_run++;
    if (r !== exp_status(1, 1)) begin tests_failed++; $display("FAIL timeout_status: got %h required %h", r, exp_status(1, 1)); end
    tests_run++;
    if (irq !== 1'b1) begin tests_failed++; $display("FAIL timeout_irq: got %b required 1", irq); end
    bus_write(2'd1, 32'h7);
    wait_flag(seen);
    tests_run++;
    if (!seen || pixel_data !== w) begin tests_failed++; $display("FAIL timeout_reissue: got %h required %h", pixel_data, w); end
`else
    for (int i = 0; i < 40; i++) begin if (pixel_flag === 1'b1) highs++; @(negedge clk); end
    tests_run++;
    if (highs != 40) begin tests_failed++; $display("FAIL no_timeout_wait: got %0d cycles required 40", highs); end
    bus_read(2'd2, r);
    tests_run++;
    if (r !== exp_status(1, 0)) begin tests_failed++; $display("FAIL no_timeout_status: got %h required %h", r, exp_status(1, 0)); end
`endif
    drain_check(1, 1);
    cleanup();
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    bit seen;
    for (int i = 0; i < 3; i++) push_word(24'($urandom));
    bus_write(2'd1, 32'h3);
    wait_flag(seen);
    reset = 1'b1;
    exp_q.delete(); m_sent = 0; m_done = 0; m_ovf = 0;
    @(negedge clk);
    tests_run++;
    if (!seen || pixel_flag !== 1'b0 || pixel_data !== 24'h0 || irq !== 1'b0) begin
      tests_failed++; $display("FAIL reset_mid_flag: got flag %b data %h irq %b required 0/0/0", pixel_flag, pixel_data, irq);
    end
    bus_read(2'd2, r);
    tests_run++;
    if (r !== 32'h2) begin tests_failed++; $display("FAIL reset_mid_status: got %h required 2", r); end
    bus_read(2'd3, r);
    tests_run++;
    if (r !== 32'h0) begin tests_failed++; $display("FAIL reset_mid_sent: got %h required 0", r); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_two_pixels();
    test_overflow();
    test_full_push_pop();
    test_enable_clear();
    test_random();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pixel_flag_sequencer.md
PIXEL_FLAG_SEQUENCER -- requirements
Module: pixel_flag_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, power of two: pixel command queue depth.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024: maximum cycles to wait for pixel_ack.
REQ-003 SHALL have port clk, input, 1: sole clock, all logic on rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port address, input, 2: Avalon-MM register select.
REQ-006 SHALL have port chipselect, input, 1: slave select.
REQ-007 SHALL have port write_n, input, 1: active-low write strobe.
REQ-008 SHALL have port writedata, input, 32: write data.
REQ-009 SHALL have port readdata, output, 32: combinational read mux on address, zero-extended.
REQ-010 SHALL have port pixel_data, output, 24: RGB word presented to display engine.
REQ-011 SHALL have port pixel_flag, output, 1: pixel valid strobe.
REQ-012 SHALL have port pixel_ack, input, 1: display engine accept.
REQ-013 SHALL have port irq, output, 1: level interrupt.

Function
REQ-014 SHALL decode write = chipselect & ~write_n; addr 0 DATA: push writedata[23:0] into FIFO.
REQ-015 SHALL implement addr 1 CTRL: bit0 enable, bit1 irq_en (R/W); bit2 clear timeout_err, bit3 clear done, bit4 clear overflow (write-1 pulses, read 0).
REQ-016 SHALL implement addr 2 STATUS (RO): bit0 busy, bit1 empty, bit2 full, bit3 timeout_err, bit4 overflow, bit5 done, bits[15:8] FIFO level.
REQ-017 SHALL implement addr 3 SENT: 16-bit count of acknowledged pixels; any write clears it; wraps 0xFFFF->0.
REQ-018 SHALL run FSM IDLE, WAIT_ACK, GAP, HALT.
REQ-019 IDLE: if enable & ~empty & ~timeout_err -> pixel_data <= FIFO head, pixel_flag <= 1, go WAIT_ACK (flag rises 1 cycle after condition).
REQ-020 WAIT_ACK: pixel_ack high -> pixel_flag <= 0, pop FIFO, SENT+1, go GAP; pixel_data stable whole state.
REQ-021 GAP: one cycle flag low, then IDLE; back-to-back pixels thus spaced >=2 cycles.
REQ-022 Clearing enable during WAIT_ACK SHALL NOT abort the handshake; FSM stops in IDLE afterwards.
REQ-023 Write to DATA while full SHALL be dropped and set sticky overflow; push and pop in same cycle SHALL both take effect.
REQ-024 done SHALL set on the pop that leaves FIFO empty; sticky until cleared.
REQ-025 irq SHALL equal irq_en & (timeout_err | done | overflow), registered-free combinational.
REQ-026 busy SHALL be 1 in WAIT_ACK, GAP, HALT.

Reset
REQ-027 reset SHALL force IDLE, FIFO empty, pixel_flag 0, pixel_data 0, CTRL 0, SENT 0, all sticky bits 0, irq 0, timeout counter 0; mid-handshake reset drops the pixel.

Configuration
REQ-028 With PIXEL_FLAG_SEQ_TIMEOUT_EN defined: counter runs in WAIT_ACK; reaching TIMEOUT_CYCLES without ack -> pixel_flag 0, timeout_err 1, entry retained, go HALT; HALT -> IDLE on clear timeout_err.
REQ-029 Without PIXEL_FLAG_SEQ_TIMEOUT_EN: no counter, WAIT_ACK waits indefinitely, HALT unreachable, STATUS bit3 reads 0.

Structure
REQ-030 Package pixel_flag_seq_pkg SHALL hold FSM state typedef, register address constants, STATUS/CTRL bit indices.
REQ-031 FIFO SHALL be sub-module pixel_flag_seq_fifo (sync, show-ahead head, level output).

Verification
REQ-032 Push 0x123456, 0xABCDEF, enable=1, ack 2 cycles after each flag -> two flags, data in order, SENT=2, done=1, empty=1.
REQ-033 Push 9 words with FIFO_DEPTH=8, enable=0 -> level=8, full=1, overflow=1; 9th word never emitted.
REQ-034 Timeout build, TIMEOUT_CYCLES=16, no ack -> flag drops at 16 cycles, timeout_err=1, irq=1 if irq_en; clear -> same pixel re-issued.
REQ-035 Clear enable in WAIT_ACK, then ack -> pixel completes, SENT+1, no further flag while FIFO non-empty.
REQ-036 Assert reset during WAIT_ACK with 3 queued -> next cycle flag=0, empty=1, SENT=0, readdata STATUS=0x2.
